// File: rtl/uart_tx_port.sv
// uart_tx_port: CPU-bus 8N1 serial transmitter fed by a byte FIFO.
// Optional feature macro: UART_TX_PORT_IRQ_EN (irq enable in CTRL bit1,
// irq = enable && FIFO empty && serialiser idle, status bit4 = enable).
//
// state | meaning
// IDLE  | txd high, waiting for a byte in the FIFO
// START | start bit (txd low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (txd high); pops straight into START if more data
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       addr,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       txd,
  output logic       irq
);
  localparam int                 DEPTH      = 2 ** FIFO_AW;
  localparam logic [15:0]        BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]     r_count;
  logic                 r_overflow;
  logic [15:0]          r_baud, w_baud_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 r_txd, w_txd_nxt;
  logic [7:0]           r_data_out;
  logic [7:0]           w_status;
  logic                 w_full, w_empty, w_busy, w_baud_done;
  logic                 w_pop, w_push_req, w_push, w_ctrl_wr;
  logic                 w_irq_en;

  assign w_full      = (r_count == COUNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_busy      = (r_state != IDLE);
  assign w_baud_done = (r_baud == '0);
  assign w_push_req  = cs && we && !addr;
  assign w_ctrl_wr   = cs && we && addr;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_push      = w_push_req && (!w_full || w_pop);

  // Serialiser next-state, baud/bit counters, shifter and FIFO pop request.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_baud_nxt  = BAUD_LAST;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_baud_nxt    = BAUD_LAST;
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nxt  = BAUD_LAST;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_baud_nxt  = BAUD_LAST;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
    endcase
  end

  // txd is registered from the next state so it changes in step with the FSM.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // Serialiser state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push)         r_overflow <= 1'b1;
      else if (w_ctrl_wr && data_in[0])  r_overflow <= 1'b0;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

`ifdef UART_TX_PORT_IRQ_EN
  logic r_irq_en, r_irq, w_irq_en_nxt;
  assign w_irq_en_nxt = w_ctrl_wr ? data_in[1] : r_irq_en;

  // Enable takes effect on the write edge; irq is a registered idle/empty flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_irq_en_nxt && w_empty && !w_busy;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

  assign w_status = {3'b000, w_irq_en, r_overflow, w_empty, w_full, w_busy};

  // Read data is refreshed every cycle from addr, independent of cs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_data_out <= '0;
    else       r_data_out <= addr ? 8'(r_count) : w_status;
  end

  assign data_out = r_data_out;
  assign txd      = r_txd;
endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port (CLKS_PER_BIT=4, FIFO_AW=2). A negedge monitor
// decodes frames on txd and compares them against a byte scoreboard.
module tb_uart_tx_port;
  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef UART_TX_PORT_IRQ_EN
  localparam logic [7:0] EN_BIT = 8'h10;
`else
  localparam logic [7:0] EN_BIT = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0, addr = 1'b0, we = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       txd, irq;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb[$];
  bit         mon_en = 1'b1;
  int         frames_done = 0;
  int         mon_k = -1;
  logic [9:0] mon_bits;
  bit         mon_shape;
  int         cyc = 0;
  int         last_end = -100;
  int         last_gap = -1;

  typedef struct {
    logic       cs;
    logic       we;
    logic       addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .we(we),
    .data_in(data_in), .data_out(data_out), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames_done < n && c < budget) begin
      tick();
      c++;
    end
    if (frames_done < n) check("frame_timeout", frames_done, n);
  endtask

  // Frame monitor: every negedge sample of a frame must match its bit cell.
  always @(negedge clk) begin
    cyc++;
    if (reset || !mon_en) begin
      mon_k = -1;
    end else begin
      if (mon_k < 0 && txd == 1'b0) begin
        mon_k     = 0;
        mon_shape = 1'b1;
        last_gap  = cyc - last_end - 1;
      end
      if (mon_k >= 0) begin
        if (mon_k % CPB == 0) mon_bits[mon_k / CPB] = txd;
        else if (txd !== mon_bits[mon_k / CPB]) mon_shape = 1'b0;
        if (mon_k == 10 * CPB - 1) begin
          check("frame_shape", {mon_shape, mon_bits[9], mon_bits[0]}, 3'b110);
          if (sb.size() == 0) check("frame_unexpected", 1, 0);
          else check("frame_byte", mon_bits[8:1], sb.pop_front());
          frames_done++;
          last_end = cyc;
          mon_k = -1;
        end else begin
          mon_k++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   busy_cnt, low_cnt, base, c;
    logic [7:0] ovf_bytes[6];

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h04};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h77, 8'h04};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h04};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 8'h03, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h04 | EN_BIT};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h04};
    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'hEE};

    // Reset state
    #22 reset = 1'b0;
    check("rst_txd", txd, 1);
    check("rst_data_out", data_out, 0);
    check("rst_irq", irq, 0);

    // Register access table (idle, empty FIFO)
    for (int i = 0; i < 9; i++) begin
      cs = vecs[i].cs; we = vecs[i].we; addr = vecs[i].addr; data_in = vecs[i].din;
      tick();
      check($sformatf("vec%0d", i), data_out, vecs[i].exp);
    end
    cs = 1'b0; we = 1'b0;

    // Single frame 0xA5: exactly 40 busy cycles
    base = frames_done;
    sb.push_back(8'hA5);
    bus_write(1'b0, 8'hA5);
    addr = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (data_out[0]) busy_cnt++;
    end
    check("a5_busy_cycles", busy_cnt, 10 * CPB);
    check("a5_status_after", data_out, 8'h04 | 8'h00);
    check("a5_frames", frames_done, base + 1);
    check("a5_irq_off", irq, 0);

    // Three back-to-back frames, count draining, no idle gap
    base = frames_done;
    for (int i = 1; i <= 3; i++) sb.push_back(8'(i));
    bus_write(1'b0, 8'h01);
    bus_write(1'b0, 8'h02);
    bus_write(1'b0, 8'h03);
    addr = 1'b1;
    tick();
    check("b2b_count2", data_out, 2);
    wait_frames(base + 1, 100);
    tick();
    check("b2b_count1", data_out, 1);
    check("b2b_gap2", last_gap, 0);
    wait_frames(base + 2, 100);
    tick();
    check("b2b_count0", data_out, 0);
    check("b2b_gap3", last_gap, 0);
    wait_frames(base + 3, 100);

    // Overflow: 1 in shifter + 4 in FIFO accepted, 6th dropped
    base = frames_done;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back(ovf_bytes[i]);
      bus_write(1'b0, ovf_bytes[i]);
    end
    addr = 1'b0;
    tick();
    check("ovf_status", data_out, 8'h0B);
    addr = 1'b1;
    tick();
    check("ovf_count", data_out, 4);
    bus_write(1'b1, 8'h01);
    addr = 1'b0;
    tick();
    check("ovf_cleared", data_out, 8'h03);

    // Push into full FIFO on the same edge the FSM pops
    c = 0;
    while (frames_done < base + 1 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("full_pop_sync", frames_done, base + 1);
    cs = 1'b1; we = 1'b1; addr = 1'b0; data_in = 8'h5A;
    sb.push_back(8'h5A);
    tick();
    cs = 1'b0; we = 1'b0;
    check("full_pop_status_pre", data_out, 8'h03);
    addr = 1'b1;
    tick();
    check("full_pop_count", data_out, 4);
    addr = 1'b0;
    tick();
    check("full_pop_no_ovf", data_out, 8'h03);
    wait_frames(base + 6, 300);

`ifdef UART_TX_PORT_IRQ_EN
    // irq: low during frame, rises one cycle after the stop bit
    base = frames_done;
    bus_write(1'b1, 8'h02);
    sb.push_back(8'h55);
    bus_write(1'b0, 8'h55);
    tick();
    c = 0;
    busy_cnt = 0;
    while (frames_done < base + 1 && c < 100) begin
      tick();
      c++;
      if (irq) busy_cnt++;
    end
    check("irq_frame_low", busy_cnt, 0);
    check("irq_at_stop_end", irq, 0);
    tick();
    check("irq_rise", irq, 1);
    bus_write(1'b1, 8'h00);
    check("irq_disable", irq, 0);
`endif

    // Asynchronous reset mid-frame discards frame and FIFO
    mon_en = 1'b0;
    bus_write(1'b0, 8'h3C);
    bus_write(1'b0, 8'h99);
    tick();
    check("rst_mid_txd_low", txd, 0);
    reset = 1'b1;
    #1;
    check("rst_mid_txd", txd, 1);
    check("rst_mid_data_out", data_out, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    addr = 1'b0;
    tick();
    check("rst_mid_status", data_out, 8'h04);
    addr = 1'b1;
    tick();
    check("rst_mid_count", data_out, 0);
    mon_en = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (txd == 1'b0) low_cnt++;
    end
    check("rst_mid_quiet", low_cnt, 0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
